// File: rtl/conv_pkg.sv
// conv_pkg: shared types and default sizes for the convolution example datapath.
package conv_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      GAP  = 2'd2
   } seq_state_t;

   localparam int DMX_LANES   = 8;
   localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/demux_lane_sequencer_gap_timer.sv
// gap_timer: loadable down-counter that times the post-frame idle window.
// expired_o is high on the last cycle of the window, so the window lasts
// exactly GAP_CYCLES cycles after a load.
module gap_timer #(
   parameter int GAP_CYCLES = 1,
   parameter int W          = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load_i,
   input  logic en_i,
   output logic expired_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // load the window length, otherwise count down while enabled
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = W'(GAP_CYCLES);
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   // counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (cnt_q <= W'(1));

endmodule

// File: rtl/demux_lane_sequencer.sv
// demux_lane_sequencer: feeds a 1-to-LANES bit demux from a serial
// valid/ready stream, one lane per accepted bit in round-robin order.
// Optional build macro SEQ_PARITY_EN: each frame carries a trailing
// even-parity bit that is checked but never strobed to the demux.
//
// state | meaning
// IDLE  | waiting for the first bit of a frame, in_ready high
// RUN   | frame in progress, in_ready high
// GAP   | forced idle after a frame, in_ready low
module demux_lane_sequencer
   import conv_pkg::*;
#(
   parameter int LANES      = DMX_LANES,
   parameter int SEL_W      = $clog2(LANES),
   parameter int GAP_CYCLES = 1,
   parameter int CNT_W      = FRAME_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             in_bit,
   output logic             in_ready,
   input  logic             abort,
   output logic             dmx_data,
   output logic [SEL_W-1:0] dmx_select,
   output logic             dmx_strobe,
   output logic             frame_done,
   output logic [CNT_W-1:0] frame_cnt,
   output logic             parity_err
);

   localparam logic [SEL_W-1:0] LAST_LANE = SEL_W'(LANES - 1);

   seq_state_t       state_q, state_d;
   logic             in_ready_q, in_ready_d;
   logic [SEL_W-1:0] lane_q, lane_d;
   logic             dmx_data_q, dmx_data_d;
   logic [SEL_W-1:0] dmx_select_q, dmx_select_d;
   logic             dmx_strobe_q, dmx_strobe_d;
   logic             frame_done_q, frame_done_d;
   logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

   logic accept;
   logic take;
   logic data_take;
   logic last_bit;
   logic frame_end;
   logic gap_load;
   logic gap_en;
   logic gap_expired;

   // in_ready is registered so it stays low throughout reset
   assign accept    = in_valid && in_ready_q;
   assign take      = accept && !abort;
   assign frame_end = take && last_bit;

`ifdef SEQ_PARITY_EN
   logic par_q, par_d;
   logic par_phase_q, par_phase_d;
   logic parity_err_q, parity_err_d;

   assign last_bit     = par_phase_q;
   assign data_take    = take && !par_phase_q;
   assign parity_err_d = frame_end && (par_q ^ in_bit);

   // running parity over data bits; par_phase marks the parity-bit slot
   always_comb begin
      par_d       = par_q;
      par_phase_d = par_phase_q;
      if (abort) begin
         par_d       = 1'b0;
         par_phase_d = 1'b0;
      end else if (take) begin
         if (par_phase_q) begin
            par_d       = 1'b0;
            par_phase_d = 1'b0;
         end else begin
            par_d = par_q ^ in_bit;
            if (lane_q == LAST_LANE) begin
               par_phase_d = 1'b1;
            end
         end
      end
   end

   // parity registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_q        <= 1'b0;
         par_phase_q  <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         par_q        <= par_d;
         par_phase_q  <= par_phase_d;
         parity_err_q <= parity_err_d;
      end
   end

   assign parity_err = parity_err_q;
`else
   assign last_bit   = (lane_q == LAST_LANE);
   assign data_take  = take;
   assign parity_err = 1'b0;
`endif

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state; abort overrides everything, including a pending gap
   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (take) begin
                  state_d = RUN;
               end
            end
            RUN: begin
               if (frame_end) begin
                  state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
               end
            end
            GAP: begin
               if (gap_expired) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // FSM outputs and datapath next values
   always_comb begin
      in_ready_d   = (state_d != GAP);
      dmx_strobe_d = data_take;
      dmx_data_d   = data_take ? in_bit : 1'b0;
      dmx_select_d = data_take ? lane_q : dmx_select_q;
      frame_done_d = frame_end;
      frame_cnt_d  = frame_end ? (frame_cnt_q + CNT_W'(1)) : frame_cnt_q;
      lane_d       = lane_q;
      if (abort) begin
         lane_d = '0;
      end else if (data_take) begin
         lane_d = (lane_q == LAST_LANE) ? '0 : (lane_q + SEL_W'(1));
      end
      gap_load = frame_end && (GAP_CYCLES != 0);
      gap_en   = (state_q == GAP);
   end

   // datapath and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_ready_q   <= 1'b0;
         lane_q       <= '0;
         dmx_data_q   <= 1'b0;
         dmx_select_q <= '0;
         dmx_strobe_q <= 1'b0;
         frame_done_q <= 1'b0;
         frame_cnt_q  <= '0;
      end else begin
         in_ready_q   <= in_ready_d;
         lane_q       <= lane_d;
         dmx_data_q   <= dmx_data_d;
         dmx_select_q <= dmx_select_d;
         dmx_strobe_q <= dmx_strobe_d;
         frame_done_q <= frame_done_d;
         frame_cnt_q  <= frame_cnt_d;
      end
   end

   gap_timer #(
      .GAP_CYCLES(GAP_CYCLES)
   ) u_gap_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_i   (gap_load),
      .en_i     (gap_en),
      .expired_o(gap_expired)
   );

   assign in_ready   = in_ready_q;
   assign dmx_data   = dmx_data_q;
   assign dmx_select = dmx_select_q;
   assign dmx_strobe = dmx_strobe_q;
   assign frame_done = frame_done_q;
   assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_demux_lane_sequencer.sv
// Bench for demux_lane_sequencer: two instances (8 lanes / gap 1 / 16-bit
// count, and 5 lanes / no gap / 2-bit count) share one stimulus stream.
module tb_demux_lane_sequencer;

   localparam int LA = 8, GA = 1, CA = 16;
   localparam int LB = 5, GB = 0, CB = 2;
`ifdef SEQ_PARITY_EN
   localparam bit PARITY = 1'b1;
`else
   localparam bit PARITY = 1'b0;
`endif

   typedef struct {
      logic strb;
      logic data;
      int   sel;
      logic done;
      int   cnt;
      logic perr;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in_valid = 1'b0;
   logic in_bit = 1'b0;
   logic abort = 1'b0;

   logic          a_ready, a_data, a_strb, a_done, a_perr;
   logic [2:0]    a_sel;
   logic [CA-1:0] a_cnt;
   logic          b_ready, b_data, b_strb, b_done, b_perr;
   logic [2:0]    b_sel;
   logic [CB-1:0] b_cnt;

   int checks = 0;
   int errors = 0;

   exp_t q0[$];
   exp_t q1[$];

   int   m_lane[2];
   int   m_gap[2];
   int   m_cnt[2];
   int   m_sel[2];
   logic m_par[2];
   logic m_pph[2];

   always #5 clk = ~clk;

   demux_lane_sequencer #(.LANES(LA), .GAP_CYCLES(GA), .CNT_W(CA)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
      .in_ready(a_ready), .abort(abort), .dmx_data(a_data), .dmx_select(a_sel),
      .dmx_strobe(a_strb), .frame_done(a_done), .frame_cnt(a_cnt), .parity_err(a_perr)
   );

   demux_lane_sequencer #(.LANES(LB), .GAP_CYCLES(GB), .CNT_W(CB)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
      .in_ready(b_ready), .abort(abort), .dmx_data(b_data), .dmx_select(b_sel),
      .dmx_strobe(b_strb), .frame_done(b_done), .frame_cnt(b_cnt), .parity_err(b_perr)
   );

   function automatic int lanes_of(input int d);
      return (d == 0) ? LA : LB;
   endfunction

   function automatic int gap_of(input int d);
      return (d == 0) ? GA : GB;
   endfunction

   function automatic int mod_of(input int d);
      return (d == 0) ? (1 << CA) : (1 << CB);
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_lane[d] = 0; m_gap[d] = 0; m_cnt[d] = 0; m_sel[d] = 0;
         m_par[d] = 1'b0; m_pph[d] = 1'b0;
      end
   endtask

   task automatic push(input int d, input exp_t e);
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   // Reference: a frame is LANES data bits (plus one parity bit when enabled);
   // after a frame the input refuses bits for GAP cycles; abort discards it.
   task automatic model_step(input int d, input logic v, input logic b, input logic ab);
      exp_t e;
      logic last;
      if (ab) begin
         m_lane[d] = 0; m_par[d] = 1'b0; m_pph[d] = 1'b0; m_gap[d] = 0;
      end else if (v && (m_gap[d] == 0)) begin
         if (m_pph[d]) begin
            m_cnt[d] = (m_cnt[d] + 1) % mod_of(d);
            e = '{strb: 1'b0, data: 1'b0, sel: m_sel[d], done: 1'b1,
                  cnt: m_cnt[d], perr: m_par[d] ^ b};
            m_pph[d] = 1'b0; m_par[d] = 1'b0; m_gap[d] = gap_of(d);
            push(d, e);
         end else begin
            m_sel[d] = m_lane[d];
            m_par[d] = m_par[d] ^ b;
            last = (m_lane[d] == lanes_of(d) - 1);
            m_lane[d] = last ? 0 : m_lane[d] + 1;
            e = '{strb: 1'b1, data: b, sel: m_sel[d], done: 1'b0, cnt: m_cnt[d], perr: 1'b0};
            if (last) begin
               if (PARITY) begin
                  m_pph[d] = 1'b1;
               end else begin
                  m_cnt[d] = (m_cnt[d] + 1) % mod_of(d);
                  e.done = 1'b1;
                  e.cnt  = m_cnt[d];
                  m_gap[d] = gap_of(d);
               end
            end
            push(d, e);
         end
      end else if (m_gap[d] > 0) begin
         m_gap[d]--;
      end
   endtask

   // one stimulus cycle: check readiness, drive inputs, advance the model
   task automatic cycle(input logic v, input logic b, input logic ab);
      @(negedge clk);
      chk("in_ready_a", int'(a_ready), (m_gap[0] == 0) ? 1 : 0);
      chk("in_ready_b", int'(b_ready), (m_gap[1] == 0) ? 1 : 0);
      in_valid = v;
      in_bit   = b;
      abort    = ab;
      model_step(0, v, b, ab);
      model_step(1, v, b, ab);
   endtask

   task automatic mon(input int d, input logic strb, input logic data, input int sel,
                      input logic done, input int cnt, input logic perr);
      exp_t e;
      int   empty;
      if (strb || done || perr) begin
         empty = (d == 0) ? q0.size() : q1.size();
         checks++;
         if (empty == 0) begin
            errors++;
            $display("FAIL out%0d_unexpected: got strb=%0b sel=%0d done=%0b, expected no event",
                     d, strb, sel, done);
         end else begin
            if (d == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            if (strb !== e.strb || data !== e.data || sel != e.sel || done !== e.done ||
                cnt != e.cnt || perr !== e.perr) begin
               errors++;
               $display("FAIL out%0d: got strb=%0b data=%0b sel=%0d done=%0b cnt=%0d perr=%0b, expected strb=%0b data=%0b sel=%0d done=%0b cnt=%0d perr=%0b",
                        d, strb, data, sel, done, cnt, perr,
                        e.strb, e.data, e.sel, e.done, e.cnt, e.perr);
            end
         end
      end else begin
         checks++;
         if (data !== 1'b0) begin
            errors++;
            $display("FAIL idle_data%0d: got %0b, expected 0", d, data);
         end
      end
   endtask

   // monitor: compares every DUT event against the scoreboard
   always @(negedge clk) begin
      if (rst_n) begin
         mon(0, a_strb, a_data, int'(a_sel), a_done, int'(a_cnt), a_perr);
         mon(1, b_strb, b_data, int'(b_sel), b_done, int'(b_cnt), b_perr);
      end
   end

   initial begin
      logic [7:0] pat;
      pat = 8'b0100_1101;   // sent LSB first: 1,0,1,1,0,0,1,0
      model_reset();

      // reset values
      repeat (3) @(negedge clk);
      chk("rst_ready_a", int'(a_ready), 0);
      chk("rst_outs_a", int'({a_strb, a_data, a_sel, a_done, a_cnt, a_perr}), 0);
      chk("rst_outs_b", int'({b_ready, b_strb, b_data, b_sel, b_done, b_cnt, b_perr}), 0);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1 chk("ready_after_rel", int'(a_ready), 1);

      // directed frame, then a second frame (bad parity when enabled)
      cycle(1'b0, 1'b0, 1'b0);
      for (int f = 0; f < 2; f++) begin
         for (int i = 0; i < 8; i++) cycle(1'b1, pat[i], 1'b0);
         if (PARITY) cycle(1'b1, (f == 1) ? 1'b1 : 1'b0, 1'b0);
         cycle(1'b0, 1'b0, 1'b0);
         cycle(1'b0, 1'b0, 1'b0);
      end

      // valid toggling every other cycle
      cycle(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 32; i++) cycle((i % 2) == 0, 1'($urandom_range(0, 1)), 1'b0);

      // abort together with the 4th accept
      cycle(1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0);
      cycle(1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 12; i++) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0);
      cycle(1'b0, 1'b0, 1'b0);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         cycle($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
               $urandom_range(0, 63) == 0);
      end

      // reset asserted mid-frame
      cycle(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_outs_a", int'({a_ready, a_strb, a_data, a_sel, a_done, a_cnt, a_perr}), 0);
      chk("midrst_outs_b", int'({b_ready, b_strb, b_data, b_sel, b_done, b_cnt, b_perr}), 0);
      in_valid = 1'b0;
      q0.delete();
      q1.delete();
      model_reset();
      @(negedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 20; i++) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0);

      // drain
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0);
      chk("drain_q0", q0.size(), 0);
      chk("drain_q1", q1.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
